blanket_0_chk: RTL and testbench
================================

Name: blanket_0_chk

Overview:
- Read-back checker for the blanket-0/blanket-1 MBIST element.
- After the blanket writer has filled the array, this block performs the following steps:
  - sweeps addresses 0..DEPTH-1 with read enables;
  - compares each returned word against the expected solid pattern (0000 or 1111, selected by rev_in);
  - reports pass/fail, the mismatch count and the first failing address.
- Sits between the MBIST controller and the memory read port, as the reader counterpart of the blanket writer.

Parameters:
- DATA_W, 4, memory word width.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words checked; must be ≤ 2**ADDR_W.
- RD_LAT, 1, cycles from the addr_out/r_en_out sample edge to valid rd_data_in; legal range 1..4.

Ports:
- clk, input, 1, sole clock; all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- en_in, input, 1, start request; sampled only in IDLE.
- rev_in, input, 1, pattern select: 0 expects all-0, 1 expects all-1; latched at start.
- rd_data_in, input, DATA_W, memory read data.
- addr_out, output, ADDR_W, read address.
- r_en_out, output, 1, read enable.
- busy, output, 1, high from start until chk_done.
- chk_done, output, 1, one-cycle pulse at the end of the sweep.
- fail, output, 1, sticky: at least one mismatch in the current/last run.
- fail_cnt, output, ADDR_W+1, number of mismatching words.
- first_fail_addr, output, ADDR_W, address of the first mismatch; valid when fail=1.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; pipe cleared.
  - Outputs: addr_out=0, r_en_out=0, busy=0, chk_done=0, fail=0, fail_cnt=0, first_fail_addr=0.
  - Applies mid-run: in-flight reads are discarded and no chk_done is produced.
- States: IDLE, READ, DRAIN, DONE.
- IDLE → READ when en_in=1. On that edge:
  - exp <= {DATA_W{rev_in}};
  - fail, fail_cnt and first_fail_addr are cleared;
  - addr_out=0, r_en_out=1, busy=1.
- READ: r_en_out=1 each cycle; addr_out increments by 1 per cycle.
  - After addr_out=DEPTH-1 has been presented for one cycle: r_en_out=0, addr_out=0, go to DRAIN.
  - The sweep issues exactly DEPTH reads with no gaps.
- DRAIN: waits until the read pipe is empty (RD_LAT cycles), then goes to DONE.
- DONE: chk_done=1 for exactly one cycle, busy=0, then IDLE.
  - fail, fail_cnt and first_fail_addr hold until the next start or reset.
- Read pipe: the {valid, addr} of each issued read is delayed by RD_LAT stages.
  - On the cycle a valid entry emerges, rd_data_in is compared with exp.
- Mismatch handling: any bit differs → fail_cnt += 1 and fail <= 1.
  - If fail was 0, first_fail_addr <= the pipe address.
  - Max count is DEPTH, which fits ADDR_W+1 bits, so there is no saturation.
- en_in is ignored outside IDLE; deasserting it mid-sweep does not abort.
  - en_in held high across DONE restarts on the following IDLE cycle.
- rev_in changes mid-run have no effect (latched value is used).
- Latency: start edge to chk_done = DEPTH + RD_LAT + 1 cycles.
- Address arithmetic is in ADDR_W bits with an ADDR_W+1-bit terminal compare, so DEPTH=2**ADDR_W terminates correctly without wrap.

Decomposition:
- Package mbist_pkg:
  - DATA_W and ADDR_W defaults;
  - state enum {IDLE, READ, DRAIN, DONE};
  - PAT_BLANK0/PAT_BLANK1 constants, shared with the blanket writer.
- Sub-module mbist_rd_pipe: RD_LAT-deep shift register carrying {valid, addr}, with synchronous active-low clear.
- Compare and counters stay in the top module.

Test Plan:
1. rev_in=0, memory all 0000, RD_LAT=1, pulse en_in:
   - 256 reads, addr 0..255;
   - chk_done 258 cycles after start;
   - fail=0, fail_cnt=0.
2. rev_in=1, memory all 1111 except addr 0x37=1011 and 0xC0=0111:
   - fail=1, fail_cnt=2, first_fail_addr=0x37.
3. rev_in=0, memory all 1111, RD_LAT=3:
   - fail_cnt=256, first_fail_addr=0x00;
   - chk_done at start+260.
4. rst_n=0 at address 0x80 mid-sweep with injected faults:
   - all outputs return to reset values next cycle;
   - no chk_done;
   - a fresh en_in run completes normally.
5. en_in held high continuously, clean memory:
   - back-to-back runs;
   - each run clears fail/fail_cnt on its start edge;
   - chk_done pulses once per run.
6. Toggle rev_in and en_in during READ:
   - no effect on sweep or expected pattern;
   - results match the latched rev_in.

Source files
------------

// File: rtl/mbist_pkg.sv
// ---------------------------------------------------------------------------
// mbist_pkg
// Definitions shared by the blanket MBIST writer and the read-back checker:
// default widths, the checker sequencing states and the solid test patterns.
// ---------------------------------------------------------------------------
package mbist_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mbist_state_e;

  // Solid background patterns written/expected by the blanket element.
  localparam logic [DATA_W_DEF-1:0] PAT_BLANK0 = '0;
  localparam logic [DATA_W_DEF-1:0] PAT_BLANK1 = '1;

endpackage

// File: rtl/mbist_rd_pipe.sv
// ---------------------------------------------------------------------------
// mbist_rd_pipe
// Delays the {valid, addr} tag of each issued read by RD_LAT cycles so the
// tag emerges on the same cycle the memory returns the matching data.
//
// Ports:
//   clk       clock
//   clr_n     synchronous active-low clear of the valid bits
//   rd_vld    a read is being issued this cycle
//   rd_addr   address of the issued read
//   cmp_vld   tag emerging from the pipe is valid
//   cmp_addr  address carried by the emerging tag
//   pipe_busy at least one valid tag is still in flight
// ---------------------------------------------------------------------------
module mbist_rd_pipe #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              cmp_vld,
  output logic [ADDR_W-1:0] cmp_addr,
  output logic              pipe_busy
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_vld;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // NOTE: the address stages are a plain shift array with no reset; their
  // contents only matter when the matching valid bit is set, and the valid
  // bits are cleared above.
  always_ff @(posedge clk) begin
    addr_q[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      addr_q[i] <= addr_q[i-1];
    end
  end

  assign cmp_vld   = vld_q[RD_LAT-1];
  assign cmp_addr  = addr_q[RD_LAT-1];
  assign pipe_busy = |vld_q;

endmodule

// File: rtl/blanket_0_chk.sv
// ---------------------------------------------------------------------------
// blanket_0_chk
// Read-back checker for the blanket-0/blanket-1 MBIST element. On start it
// sweeps addresses 0..DEPTH-1 with back-to-back reads, compares every
// returned word with the solid pattern selected by rev_in (latched at start)
// and reports pass/fail, the mismatch count and the first failing address.
//
// Ports:
//   clk             clock, all logic on posedge
//   rst_n           synchronous active-low reset
//   en_in           start request, only looked at in IDLE
//   rev_in          0: expect all-0 words, 1: expect all-1 words
//   rd_data_in      memory read data, valid RD_LAT cycles after the read
//   addr_out        read address
//   r_en_out        read enable
//   busy            sweep or drain in progress
//   chk_done        one-cycle pulse at the end of the run
//   fail            sticky: at least one mismatch in the current/last run
//   fail_cnt        number of mismatching words
//   first_fail_addr address of the first mismatch (valid when fail=1)
// ---------------------------------------------------------------------------
module blanket_0_chk
  import mbist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic              rev_in,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              r_en_out,
  output logic              busy,
  output logic              chk_done,
  output logic              fail,
  output logic [ADDR_W:0]   fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr
);

  // Terminal compare is one bit wider than the address so DEPTH = 2**ADDR_W
  // ends on the last address instead of relying on wrap-around.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  mbist_state_e      state_q, state_d;
  logic [DATA_W-1:0] exp_q;
  logic              start;
  logic              last_addr;
  logic              mismatch;
  logic              pipe_vld;
  logic              pipe_busy;
  logic [ADDR_W-1:0] pipe_addr;

  assign start     = (state_q == IDLE) && en_in;
  assign last_addr = ({1'b0, addr_out} == LAST_ADDR);
  assign mismatch  = pipe_vld && (rd_data_in != exp_q);

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    r_en_out = 1'b0;
    busy     = 1'b0;
    chk_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_in) state_d = READ;
      end
      READ: begin
        r_en_out = 1'b1;
        busy     = 1'b1;
        if (last_addr) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // The last tag entered the pipe on the READ->DRAIN edge, so the pipe
        // is never empty on the first DRAIN cycle.
        if (!pipe_busy) state_d = DONE;
      end
      DONE: begin
        chk_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Address generator, expected pattern and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_out        <= '0;
      exp_q           <= '0;
      fail            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
    end else if (start) begin
      addr_out        <= '0;
      exp_q           <= {DATA_W{rev_in}};
      fail            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
    end else begin
      if (state_q == READ) begin
        addr_out <= last_addr ? '0 : addr_out + ADDR_W'(1);
      end
      // The count cannot exceed DEPTH, which fits ADDR_W+1 bits.
      if (mismatch) begin
        fail     <= 1'b1;
        fail_cnt <= fail_cnt + (ADDR_W+1)'(1);
        if (!fail) first_fail_addr <= pipe_addr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read tag pipe: lines each returned word up with its address
  // ---------------------------------------------------------------------
  mbist_rd_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .clr_n     (rst_n),
    .rd_vld    (r_en_out),
    .rd_addr   (addr_out),
    .cmp_vld   (pipe_vld),
    .cmp_addr  (pipe_addr),
    .pipe_busy (pipe_busy)
  );

endmodule

// File: tb/tb_blanket_0_chk.sv
// ---------------------------------------------------------------------------
// tb_blanket_0_chk
// Two checker instances (read latency 1 and 3) share one memory image. Each
// instance has its own read-latency memory model. Expected results come from
// counting words that differ from the solid pattern of the latched rev value.
// ---------------------------------------------------------------------------
module tb_blanket_0_chk;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int LAT0   = 1;
  localparam int LAT1   = 3;

  typedef struct {
    int wait_cyc;
    int lat;
    int nreads;
    int seq_err;
    int busy_err;
    int st_fail;
    int st_cnt;
    int done_after;
    int fail;
    int cnt;
    int ffa;
  } run_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              en0, en1, rev0, rev1;
  logic [DATA_W-1:0] rd0, rd1, l1_a, l1_b;
  logic [ADDR_W-1:0] addr0, addr1, ffa0, ffa1;
  logic              ren0, ren1, busy0, busy1, done0, done1, fail0, fail1;
  logic [ADDR_W:0]   cnt0, cnt1;

  logic [DATA_W-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // Observation mux for the instance under test.
  int                sel;
  logic [ADDR_W-1:0] s_addr, s_ffa;
  logic              s_ren, s_busy, s_done, s_fail;
  logic [ADDR_W:0]   s_cnt;

  always_comb begin
    if (sel == 0) begin
      s_addr = addr0; s_ren = ren0; s_busy = busy0; s_done = done0;
      s_fail = fail0; s_cnt = cnt0; s_ffa = ffa0;
    end else begin
      s_addr = addr1; s_ren = ren1; s_busy = busy1; s_done = done1;
      s_fail = fail1; s_cnt = cnt1; s_ffa = ffa1;
    end
  end

  blanket_0_chk #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(LAT0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_in(en0), .rev_in(rev0), .rd_data_in(rd0),
    .addr_out(addr0), .r_en_out(ren0), .busy(busy0), .chk_done(done0),
    .fail(fail0), .fail_cnt(cnt0), .first_fail_addr(ffa0)
  );

  blanket_0_chk #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_in(en1), .rev_in(rev1), .rd_data_in(rd1),
    .addr_out(addr1), .r_en_out(ren1), .busy(busy1), .chk_done(done1),
    .fail(fail1), .fail_cnt(cnt1), .first_fail_addr(ffa1)
  );

  // Memory read ports: junk data when no read is issued, so any compare of
  // an invalid slot is likely to show up as a wrong count.
  always @(posedge clk) rd0 <= ren0 ? mem[addr0] : DATA_W'($urandom);
  always @(posedge clk) begin
    l1_a <= ren1 ? mem[addr1] : DATA_W'($urandom);
    l1_b <= l1_a;
    rd1  <= l1_b;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Reference model and helpers
  // ---------------------------------------------------------------------
  function automatic void ref_result(input logic rev, output int cnt, output int first);
    logic [DATA_W-1:0] pat;
    pat   = {DATA_W{rev}};
    cnt   = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== pat) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
  endfunction

  function automatic int exp_lat(input int which);
    return DEPTH + ((which == 0) ? LAT0 : LAT1) + 1;
  endfunction

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int a = 0; a < DEPTH; a++) mem[a] = v;
  endtask

  // Background of the given pattern with roughly 1 in 'dens' words flipped.
  task automatic fill_random(input logic rev, input int dens);
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = {DATA_W{rev}};
      if ($urandom_range(dens - 1) == 0) mem[a] = mem[a] ^ DATA_W'($urandom_range(15, 1));
    end
  endtask

  task automatic drive(input int which, input logic en, input logic rev);
    if (which == 0) begin en0 = en; rev0 = rev; end
    else            begin en1 = en; rev1 = rev; end
  endtask

  // Starts a run and follows it to chk_done. en_mode: 0 pulse, 1 hold high,
  // 2 random toggling of en_in/rev_in during the sweep.
  task automatic run_once(input int which, input logic rev, input int en_mode, output run_t r);
    r = '{default: 0};
    r.lat = -1;
    sel = which;
    drive(which, 1'b1, rev);
    do begin
      @(negedge clk);
      r.wait_cyc++;
    end while (!s_busy && r.wait_cyc < 8);
    if (!s_busy) begin
      drive(which, 1'b0, rev);
      return;
    end
    r.st_fail = int'(s_fail);
    r.st_cnt  = int'(s_cnt);
    for (int k = 0; k < DEPTH + 16; k++) begin
      if (k > 0) @(negedge clk);
      if (en_mode == 0) drive(which, 1'b0, rev);
      else if (en_mode == 2) drive(which, (k < 200) ? 1'($urandom) : 1'b0, 1'($urandom));
      if (s_done) begin
        r.lat = k;
        if (s_busy) r.busy_err++;
        break;
      end
      if (!s_busy) r.busy_err++;
      if (s_ren !== (k < DEPTH)) r.seq_err++;
      if (s_ren) begin
        if (s_addr !== ADDR_W'(r.nreads)) r.seq_err++;
        r.nreads++;
      end
    end
    r.fail = int'(s_fail);
    r.cnt  = int'(s_cnt);
    r.ffa  = int'(s_ffa);
    if (r.lat >= 0) begin
      @(negedge clk);
      r.done_after = int'(s_done);
    end
    if (en_mode != 1) drive(which, 1'b0, rev);
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] st;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sel = w;
      #1;
      st = {s_addr, s_ren, s_busy, s_done, s_fail, s_cnt, s_ffa};
      checks++;
      if (st !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h expected 0", w, st);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    run_t r;
    fill('0);
    run_once(0, 1'b0, 0, r);
    checks++; if (r.wait_cyc !== 1) begin errors++; $display("FAIL clean_start: got %0d expected 1", r.wait_cyc); end
    checks++; if (r.lat !== 258) begin errors++; $display("FAIL clean_latency: got %0d expected 258", r.lat); end
    checks++; if (r.nreads !== 256 || r.seq_err !== 0) begin errors++; $display("FAIL clean_sweep: reads %0d seq_err %0d expected 256/0", r.nreads, r.seq_err); end
    checks++; if (r.busy_err !== 0 || r.done_after !== 0) begin errors++; $display("FAIL clean_busy_done: busy_err %0d done_after %0d expected 0/0", r.busy_err, r.done_after); end
    checks++; if (r.fail !== 0 || r.cnt !== 0) begin errors++; $display("FAIL clean_result: fail %0d cnt %0d expected 0/0", r.fail, r.cnt); end
  endtask

  task automatic test_two_faults();
    run_t r;
    fill('1);
    mem[8'h37] = 4'b1011;
    mem[8'hC0] = 4'b0111;
    run_once(0, 1'b1, 0, r);
    checks++; if (r.fail !== 1 || r.cnt !== 2) begin errors++; $display("FAIL two_faults_count: fail %0d cnt %0d expected 1/2", r.fail, r.cnt); end
    checks++; if (r.ffa !== 8'h37) begin errors++; $display("FAIL two_faults_first: got %h expected 37", r.ffa); end
    checks++; if (r.lat !== 258) begin errors++; $display("FAIL two_faults_latency: got %0d expected 258", r.lat); end
  endtask

  task automatic test_all_fail_lat3();
    run_t r;
    fill('1);
    run_once(1, 1'b0, 0, r);
    checks++; if (r.fail !== 1 || r.cnt !== 256) begin errors++; $display("FAIL lat3_count: fail %0d cnt %0d expected 1/256", r.fail, r.cnt); end
    checks++; if (r.ffa !== 0) begin errors++; $display("FAIL lat3_first: got %h expected 00", r.ffa); end
    checks++; if (r.lat !== 260) begin errors++; $display("FAIL lat3_latency: got %0d expected 260", r.lat); end
    checks++; if (r.nreads !== 256 || r.seq_err !== 0 || r.busy_err !== 0) begin errors++; $display("FAIL lat3_sweep: reads %0d seq_err %0d busy_err %0d expected 256/0/0", r.nreads, r.seq_err, r.busy_err); end
  endtask

  task automatic test_mid_reset();
    run_t r;
    logic [31:0] st;
    int n, dones, busies, ecnt, efirst;
    fill('0);
    mem[8'h10] = 4'b0100;
    mem[8'h40] = 4'b1111;
    mem[8'hA0] = 4'b0001;
    sel = 0;
    drive(0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    n = 0;
    while (s_addr !== 8'h80 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (s_addr !== 8'h80) begin errors++; $display("FAIL midrst_reach: got addr %h expected 80", s_addr); end
    checks++; if (s_fail !== 1'b1 || s_cnt !== 9'd2) begin errors++; $display("FAIL midrst_prefail: fail %0d cnt %0d expected 1/2", s_fail, s_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    st = {s_addr, s_ren, s_busy, s_done, s_fail, s_cnt, s_ffa};
    checks++; if (st !== 32'h0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", st); end
    rst_n = 1'b1;
    dones = 0;
    busies = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_done) dones++;
      if (s_busy) busies++;
    end
    checks++; if (dones !== 0 || busies !== 0) begin errors++; $display("FAIL midrst_quiet: dones %0d busy cycles %0d expected 0/0", dones, busies); end
    run_once(0, 1'b0, 0, r);
    ref_result(1'b0, ecnt, efirst);
    checks++; if (r.cnt !== ecnt || r.ffa !== efirst || r.fail !== 1) begin errors++; $display("FAIL midrst_rerun: cnt %0d first %0d fail %0d expected %0d/%0d/1", r.cnt, r.ffa, r.fail, ecnt, efirst); end
    checks++; if (r.lat !== 258) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 258", r.lat); end
  endtask

  task automatic test_back_to_back();
    run_t r;
    fill('0);
    mem[8'h05] = 4'b1000;
    run_once(0, 1'b0, 0, r);
    checks++; if (r.fail !== 1 || r.cnt !== 1) begin errors++; $display("FAIL b2b_setup: fail %0d cnt %0d expected 1/1", r.fail, r.cnt); end
    fill('0);
    for (int i = 0; i < 3; i++) begin
      run_once(0, 1'b0, 1, r);
      checks++; if (r.wait_cyc !== 1) begin errors++; $display("FAIL b2b_restart run%0d: got %0d expected 1", i, r.wait_cyc); end
      checks++; if (r.st_fail !== 0 || r.st_cnt !== 0) begin errors++; $display("FAIL b2b_clear run%0d: fail %0d cnt %0d expected 0/0", i, r.st_fail, r.st_cnt); end
      checks++; if (r.lat !== 258 || r.done_after !== 0) begin errors++; $display("FAIL b2b_done run%0d: lat %0d done_after %0d expected 258/0", i, r.lat, r.done_after); end
      checks++; if (r.fail !== 0 || r.cnt !== 0 || r.seq_err !== 0) begin errors++; $display("FAIL b2b_result run%0d: fail %0d cnt %0d seq_err %0d expected 0/0/0", i, r.fail, r.cnt, r.seq_err); end
    end
    drive(0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_toggle();
    run_t r;
    int ecnt, efirst;
    fill('1);
    mem[$urandom_range(255)] = 4'b1110;
    mem[$urandom_range(255)] = 4'b0000;
    mem[$urandom_range(255)] = 4'b0101;
    ref_result(1'b1, ecnt, efirst);
    run_once(0, 1'b1, 2, r);
    checks++; if (r.cnt !== ecnt || r.ffa !== efirst || r.fail !== int'(ecnt != 0)) begin errors++; $display("FAIL toggle_result: cnt %0d first %0d fail %0d expected %0d/%0d/%0d", r.cnt, r.ffa, r.fail, ecnt, efirst, int'(ecnt != 0)); end
    checks++; if (r.lat !== 258 || r.nreads !== 256 || r.seq_err !== 0 || r.busy_err !== 0) begin errors++; $display("FAIL toggle_sweep: lat %0d reads %0d seq_err %0d busy_err %0d expected 258/256/0/0", r.lat, r.nreads, r.seq_err, r.busy_err); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    run_t r;
    int which, ecnt, efirst;
    logic rev;
    for (int i = 0; i < 6; i++) begin
      which = int'($urandom_range(1));
      rev   = 1'($urandom);
      fill_random(rev, (i == 5) ? 1 : int'($urandom_range(40, 4)));
      ref_result(rev, ecnt, efirst);
      run_once(which, rev, 0, r);
      checks++; if (r.cnt !== ecnt || r.fail !== int'(ecnt != 0)) begin errors++; $display("FAIL rand%0d_count dut%0d: cnt %0d fail %0d expected %0d/%0d", i, which, r.cnt, r.fail, ecnt, int'(ecnt != 0)); end
      checks++; if (ecnt != 0 && r.ffa !== efirst) begin errors++; $display("FAIL rand%0d_first dut%0d: got %0d expected %0d", i, which, r.ffa, efirst); end
      checks++; if (r.lat !== exp_lat(which) || r.seq_err !== 0) begin errors++; $display("FAIL rand%0d_timing dut%0d: lat %0d seq_err %0d expected %0d/0", i, which, r.lat, r.seq_err, exp_lat(which)); end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    en0 = 1'b0; en1 = 1'b0; rev0 = 1'b0; rev1 = 1'b0;
    sel = 0;
    rst_n = 1'b0;
    fill('0);
    test_reset();
    test_clean();
    test_two_faults();
    test_all_fail_lat3();
    test_mid_reset();
    test_back_to_back();
    test_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
